// File: rtl/sb_config_loader_pkg.sv
// Shared definitions for the switch-box configuration loader: header layout,
// default broadcast address and FSM state encoding.
package sb_config_loader_pkg;

   localparam int         CFG_WORD_W   = 32;
   localparam logic [7:0] BCAST_ID_DEF = 8'hFF;

   // Header word layout: [31:24] dest, [23:16] payload count, [15:0] reserved (zero)
   localparam int HDR_DEST_LSB = 24;
   localparam int HDR_CNT_LSB  = 16;
   localparam int HDR_RSV_W    = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SKIP  = 2'd2,
      CHECK = 2'd3
   } state_t;

endpackage

// File: rtl/sb_config_loader_xor_accum.sv
// Running XOR of a frame: clr loads the header word, acc_en folds in payload words.
module cfg_xor_accum
   import sb_config_loader_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clr,
   input  logic                  acc_en,
   input  logic [CFG_WORD_W-1:0] din,
   output logic [CFG_WORD_W-1:0] acc
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      acc <= '0;
      else if (clr)    acc <= din;
      else if (acc_en) acc <= acc ^ din;
   end

endmodule

// File: rtl/sb_config_loader.sv
// Tile-filtering configuration stream loader feeding a switch-box config register.
// Optional trailer checksum enabled by defining SB_CONFIG_LOADER_CHECKSUM_EN.
module sb_config_loader
   import sb_config_loader_pkg::*;
#(
   parameter logic [7:0] TILE_ID  = 8'h00,
   parameter logic [7:0] BCAST_ID = BCAST_ID_DEF,
   parameter int         DATA_W   = CFG_WORD_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] cfg_in_data,
   input  logic              cfg_in_valid,
   output logic              cfg_in_ready,
   output logic [DATA_W-1:0] config_data,
   output logic              config_en,
   output logic              busy,
   output logic              done,
   output logic              err
);

   state_t     state, state_d;
   logic [7:0] cnt, cnt_d;
   logic       ready_q, done_pend;
   logic       strobe_d, done_d, pend_d, err_d;
   logic       xfer, hdr_bad, hdr_hit;
   logic [7:0] hdr_dest, hdr_cnt;

   assign xfer         = cfg_in_valid & cfg_in_ready;
   assign cfg_in_ready = ready_q;
   assign busy         = (state != IDLE);

   assign hdr_dest = cfg_in_data[HDR_DEST_LSB +: 8];
   assign hdr_cnt  = cfg_in_data[HDR_CNT_LSB +: 8];
   assign hdr_bad  = |cfg_in_data[HDR_RSV_W-1:0];
   // A reserved-bit violation forces the frame to be skipped even if addressed to us
   assign hdr_hit  = ((hdr_dest == TILE_ID) || (hdr_dest == BCAST_ID)) && !hdr_bad;

`ifdef SB_CONFIG_LOADER_CHECKSUM_EN
   logic                  chk_load, chk_load_d;
   logic [CFG_WORD_W-1:0] xor_acc;

   cfg_xor_accum u_xor (
      .clk    (clk),
      .reset  (reset),
      .clr    (xfer && (state == IDLE)),
      .acc_en (xfer && ((state == LOAD) || (state == SKIP))),
      .din    (cfg_in_data),
      .acc    (xor_acc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) chk_load <= 1'b0;
      else        chk_load <= chk_load_d;
   end
`endif

   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      strobe_d = 1'b0;
      pend_d   = 1'b0;
      done_d   = done_pend;
      err_d    = err;
`ifdef SB_CONFIG_LOADER_CHECKSUM_EN
      chk_load_d = chk_load;
`endif
      case (state)
         IDLE: if (xfer) begin
            cnt_d = hdr_cnt;
            if (hdr_bad)      err_d = 1'b1;
            else if (hdr_hit) err_d = 1'b0;
`ifdef SB_CONFIG_LOADER_CHECKSUM_EN
            chk_load_d = hdr_hit;
            if (hdr_cnt == 8'd0) state_d = CHECK;
            else                 state_d = hdr_hit ? LOAD : SKIP;
`else
            if (hdr_cnt == 8'd0) done_d = done_pend | hdr_hit;
            else                 state_d = hdr_hit ? LOAD : SKIP;
`endif
         end
         LOAD, SKIP: if (xfer) begin
            cnt_d    = cnt - 8'd1;
            strobe_d = (state == LOAD);
            if (cnt == 8'd1) begin
`ifdef SB_CONFIG_LOADER_CHECKSUM_EN
               state_d = CHECK;
`else
               state_d = IDLE;
               // done trails the last strobe by one cycle
               pend_d  = (state == LOAD);
`endif
            end
         end
`ifdef SB_CONFIG_LOADER_CHECKSUM_EN
         CHECK: if (xfer) begin
            state_d = IDLE;
            if (chk_load) begin
               if (xor_acc == cfg_in_data) done_d = 1'b1;
               else                        err_d  = 1'b1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cnt         <= 8'd0;
         ready_q     <= 1'b0;
         config_en   <= 1'b0;
         config_data <= '0;
         done        <= 1'b0;
         done_pend   <= 1'b0;
         err         <= 1'b0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         ready_q   <= 1'b1;
         config_en <= strobe_d;
         if (strobe_d) config_data <= cfg_in_data;
         done      <= done_d;
         done_pend <= pend_d;
         err       <= err_d;
      end
   end

endmodule

// File: tb/tb_sb_config_loader.sv
// Directed bench for sb_config_loader (default build; trailer test only with
// SB_CONFIG_LOADER_CHECKSUM_EN defined).
module tb_sb_config_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] cfg_in_data = '0;
   logic        cfg_in_valid = 1'b0;
   logic        cfg_in_ready;
   logic [31:0] config_data;
   logic        config_en, busy, done, err;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   logic [31:0] sq[$];
   int          scyc[$];
   int          dcyc[$];

   sb_config_loader #(.TILE_ID(8'h00), .BCAST_ID(8'hFF), .DATA_W(32)) dut (
      .clk(clk), .reset(reset), .cfg_in_data(cfg_in_data), .cfg_in_valid(cfg_in_valid),
      .cfg_in_ready(cfg_in_ready), .config_data(config_data), .config_en(config_en),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Log strobes and done pulses mid-cycle, stamped with the accepting edge count
   always @(negedge clk) begin
      if (config_en === 1'b1) begin
         sq.push_back(config_data);
         scyc.push_back(cyc);
      end
      if (done === 1'b1) dcyc.push_back(cyc);
   end

   task automatic clear_logs();
      sq.delete();
      scyc.delete();
      dcyc.delete();
   endtask

   task automatic put(input logic [31:0] w);
      cfg_in_data  = w;
      cfg_in_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      cfg_in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #12;
      total++; if (cfg_in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", cfg_in_ready); end
      total++; if ({config_en, done, err, busy} !== 4'b0) begin bad++; $display("FAIL rst_flags got=%b want=0000", {config_en, done, err, busy}); end
      total++; if (config_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h want=0", config_data); end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      total++; if (cfg_in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b want=1", cfg_in_ready); end
   endtask

   task automatic test_load();
      int h;
      clear_logs();
      put(32'h0003_0000);
      h = cyc;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL t1_busy got=%b want=1", busy); end
      put(32'hA0A0_0001);
      put(32'hB0B0_0002);
      put(32'hC0C0_0003);
      idle(3);
      total++; if (sq.size() !== 3) begin bad++; $display("FAIL t1_nstrobe got=%0d want=3", sq.size()); end
      total++; if (sq.size() == 3 && {sq[0], sq[1], sq[2]} !== {32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003})
         begin bad++; $display("FAIL t1_data got=%h %h %h want=a0a00001 b0b00002 c0c00003", sq[0], sq[1], sq[2]); end
      total++; if (scyc.size() == 3 && {scyc[0], scyc[2]} !== {h + 1, h + 3})
         begin bad++; $display("FAIL t1_strobe_cyc got=%0d..%0d want=%0d..%0d", scyc[0], scyc[2], h + 1, h + 3); end
      total++; if (dcyc.size() !== 1) begin bad++; $display("FAIL t1_ndone got=%0d want=1", dcyc.size()); end
      total++; if (dcyc.size() == 1 && dcyc[0] !== h + 4) begin bad++; $display("FAIL t1_done_cyc got=%0d want=%0d", dcyc[0], h + 4); end
      total++; if ({err, busy} !== 2'b00) begin bad++; $display("FAIL t1_err_busy got=%b want=00", {err, busy}); end
      total++; if (config_data !== 32'hC0C0_0003) begin bad++; $display("FAIL t1_hold got=%h want=c0c00003", config_data); end
   endtask

   task automatic test_skip();
      clear_logs();
      put(32'h0502_0000);
      put(32'h1234_5678);
      put(32'h9ABC_DEF0);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t2_busy_after got=%b want=0", busy); end
      put(32'h0001_0000);
      put(32'hD0D0_0004);
      idle(3);
      total++; if (sq.size() !== 1) begin bad++; $display("FAIL t2_nstrobe got=%0d want=1", sq.size()); end
      total++; if (sq.size() == 1 && sq[0] !== 32'hD0D0_0004) begin bad++; $display("FAIL t2_data got=%h want=d0d00004", sq[0]); end
      total++; if (dcyc.size() !== 1) begin bad++; $display("FAIL t2_ndone got=%0d want=1", dcyc.size()); end
   endtask

   task automatic test_bcast_zero();
      int h;
      clear_logs();
      put(32'hFF01_0000);
      put(32'hE0E0_0005);
      idle(3);
      total++; if (sq.size() !== 1 || sq[0] !== 32'hE0E0_0005) begin bad++; $display("FAIL t3_bcast_strobe got=%0d/%h want=1/e0e00005", sq.size(), config_data); end
      total++; if (dcyc.size() !== 1) begin bad++; $display("FAIL t3_bcast_done got=%0d want=1", dcyc.size()); end
      clear_logs();
      put(32'h0000_0000);
      h = cyc;
      idle(3);
      total++; if (sq.size() !== 0) begin bad++; $display("FAIL t3_zero_strobe got=%0d want=0", sq.size()); end
      total++; if (dcyc.size() !== 1 || dcyc[0] !== h) begin bad++; $display("FAIL t3_zero_done got=%0d want=1 at %0d", dcyc.size(), h); end
   endtask

   task automatic test_err();
      clear_logs();
      put(32'h0001_0001);
      total++; if (err !== 1'b1) begin bad++; $display("FAIL t4_err_set got=%b want=1", err); end
      put(32'hF0F0_0006);
      put(32'h0500_0000);
      idle(2);
      total++; if ({sq.size(), dcyc.size()} !== {32'd0, 32'd0}) begin bad++; $display("FAIL t4_bad_frame strobes=%0d dones=%0d want=0/0", sq.size(), dcyc.size()); end
      total++; if (err !== 1'b1) begin bad++; $display("FAIL t4_err_sticky got=%b want=1", err); end
      put(32'h0001_0000);
      total++; if (err !== 1'b0) begin bad++; $display("FAIL t4_err_clear got=%b want=0", err); end
      put(32'h6060_0007);
      idle(3);
      total++; if (sq.size() !== 1 || dcyc.size() !== 1) begin bad++; $display("FAIL t4_recover strobes=%0d dones=%0d want=1/1", sq.size(), dcyc.size()); end
   endtask

   task automatic test_stall_reset();
      clear_logs();
      put(32'h0004_0000);
      put(32'h1111_0001);
      idle(2);
      put(32'h2222_0002);
      idle(3);
      total++; if ({busy, sq.size()} !== {1'b1, 32'd2}) begin bad++; $display("FAIL t5_stall busy=%b strobes=%0d want=1/2", busy, sq.size()); end
      #2;
      reset = 1'b0;
      #1;
      total++; if ({config_en, done, err, busy, cfg_in_ready} !== 5'b0) begin bad++; $display("FAIL t5_abort_flags got=%b want=00000", {config_en, done, err, busy, cfg_in_ready}); end
      total++; if (config_data !== 32'h0) begin bad++; $display("FAIL t5_abort_data got=%h want=0", config_data); end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      total++; if (dcyc.size() !== 0) begin bad++; $display("FAIL t5_no_done got=%0d want=0", dcyc.size()); end
      clear_logs();
      put(32'h0002_0000);
      put(32'h3333_0003);
      put(32'h4444_0004);
      idle(3);
      total++; if (sq.size() !== 2 || sq[1] !== 32'h4444_0004 || dcyc.size() !== 1)
         begin bad++; $display("FAIL t5_next_frame strobes=%0d dones=%0d data=%h want=2/1/44440004", sq.size(), dcyc.size(), config_data); end
   endtask

`ifdef SB_CONFIG_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      int t;
      clear_logs();
      put(32'h0002_0000);
      put(32'h1111_2222);
      put(32'h0F0F_0000);
      put(32'h1E1C_2222);
      t = cyc;
      idle(3);
      total++; if (sq.size() !== 2 || dcyc.size() !== 1 || dcyc[0] !== t)
         begin bad++; $display("FAIL t6_good strobes=%0d dones=%0d want=2/1 at %0d", sq.size(), dcyc.size(), t); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL t6_good_err got=%b want=0", err); end
      clear_logs();
      put(32'h0002_0000);
      put(32'h1111_2222);
      put(32'h0F0F_0000);
      put(32'h1E1C_2223);
      idle(3);
      total++; if (sq.size() !== 2 || dcyc.size() !== 0 || err !== 1'b1)
         begin bad++; $display("FAIL t6_bad strobes=%0d dones=%0d err=%b want=2/0/1", sq.size(), dcyc.size(), err); end
   endtask
`endif

   initial begin
      test_reset();
`ifdef SB_CONFIG_LOADER_CHECKSUM_EN
      test_checksum();
`else
      test_load();
      test_skip();
      test_bcast_zero();
      test_err();
      test_stall_reset();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
